// File: rtl/mmul_seq_arb.sv
// Round-robin arbitrated, bit-serial interleaved modular multiplier: res_c = (a*b) mod P.
// Optional build macro MMUL_EARLY_TERM_EN: stop once the remaining multiplier bits are zero.
module mmul_seq_arb #(
  parameter int          W = 256,
  parameter logic [W-1:0] P = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_c,
  output logic         res_tag,
  output logic         busy
);

  localparam int             IW        = $clog2(W);
  localparam logic [IW-1:0]  ITER_LAST = IW'(W - 1);
  localparam logic [W:0]     P_EXT     = {1'b0, P};

  typedef enum logic [1:0] {IDLE, ADD, RED, DONE} state_t;

  state_t        state, state_next;
  logic          rr_last, tag;
  logic          grant, grant_valid, exit_red;
  logic [W-1:0]  a_r, b_r, acc_a, acc_b, b_red;
  logic [W:0]    c, c_red, b2;
  logic [IW-1:0] iter;

  // On a tie the requester that did not win last time gets the core.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant       = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
    acc_a       = grant ? req1_a : req0_a;
    acc_b       = grant ? req1_b : req0_b;
    req0_ready  = (state == IDLE) && grant_valid && !grant;
    req1_ready  = (state == IDLE) && grant_valid && grant;
  end

  always_comb begin
    c_red = (c >= P_EXT) ? c - P_EXT : c;
    b2    = {b_r, 1'b0};
    b_red = (b2 >= P_EXT) ? W'(b2 - P_EXT) : b2[W-1:0];
`ifdef MMUL_EARLY_TERM_EN
    exit_red = (iter == ITER_LAST) || (a_r[W-1:1] == '0);
`else
    exit_red = (iter == ITER_LAST);
`endif
  end

  always_comb begin
    state_next = state;
    res_valid  = (state == DONE);
    res_c      = c[W-1:0];
    res_tag    = tag;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_valid) begin
`ifdef MMUL_EARLY_TERM_EN
          state_next = (acc_a == '0) ? DONE : ADD;
`else
          state_next = ADD;
`endif
        end
      end
      ADD:     state_next = RED;
      RED:     state_next = exit_red ? DONE : ADD;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // c stays below 2P after ADD, so a single conditional subtract in RED restores c < P.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      a_r     <= '0;
      b_r     <= '0;
      c       <= '0;
      tag     <= 1'b0;
      iter    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            rr_last <= grant;
            a_r     <= acc_a;
            b_r     <= acc_b;
            c       <= '0;
            tag     <= grant;
            iter    <= '0;
          end
        end
        ADD: c <= c + (a_r[0] ? {1'b0, b_r} : '0);
        RED: begin
          c    <= c_red;
          a_r  <= a_r >> 1;
          b_r  <= b_red;
          iter <= iter + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mmul_seq_arb.md
Name: mmul_seq_arb

Overview:
- Shares one bit-serial interleaved modular multiplier (c = a·b mod P, shift-add with conditional subtract) between two requesters.
- Contains the multiplier datapath registers and the FSM that sequences them.
- Contains a round-robin arbiter that grants the core and returns the tagged result on a single valid/ready output.
- Sits between the point-arithmetic schedulers and the modular-arithmetic layer.

Parameters:
- W, 256, operand/result width in bits.
- P, 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF, modulus (SM2 prime).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  W  multiplier operand, must be < P.
- req0_b  in  W  multiplicand operand, must be < P.
- req1_valid, req1_ready, req1_a, req1_b: same as the requester-0 ports, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_c  out  W  (a·b) mod P.
- res_tag  out  1  index of requester that owns res_c.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: state=IDLE; rr_last=1 (requester 0 wins first tie); c, a, b = 0; res_valid=0; res_tag=0; busy=0.
- reqN_ready is combinational: high only in IDLE and only for the granted requester. The other ready stays 0.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant ~rr_last.
  - On acceptance, rr_last <= granted index.
- Acceptance edge: a_r <= reqN_a; b_r <= reqN_b; c <= 0; tag <= N; iter <= 0; next state ADD. With early termination, a zero a goes straight to DONE.
- FSM states:
  - IDLE: described above.
  - ADD: c <= c + (a_r[0] ? b_r : 0), computed at W+1 bits. No overflow, since c<P and b<P.
  - RED:
    - c <= (c >= P) ? c−P : c.
    - a_r <= a_r>>1.
    - b2 = {b_r,1'b0} at W+1 bits; b_r <= (b2 >= P) ? b2−P : b2.
    - iter <= iter+1.
    - Exit to DONE when iter == W−1, or when early termination applies (see Optional Feature). Otherwise back to ADD.
  - DONE: res_valid=1; res_c=c[W−1:0]; res_tag=tag. Outputs held stable until res_ready. The edge with res_valid&res_ready returns to IDLE.
- Latency: for n iterations, res_valid is high after the (T+2n)th edge, where T is the accepting edge.
- Back-to-back: no new request is accepted during the DONE→IDLE handshake cycle. The earliest next acceptance is the edge after the result is taken, so throughput is one op per 2n+2 cycles.
- Requester valid deasserting while not granted: ignored. Operands are sampled only at the accepting edge.
- Reset mid-operation (any state): abort. All registers take reset values, no result is emitted, and the in-flight request is lost.
- iter is a log2(W)-bit counter. It wraps only at W−1, which is the exit point.

Optional Feature:
- Macro: MMUL_EARLY_TERM_EN.
- Defined:
  - RED also exits to DONE when (a_r>>1)==0.
  - Acceptance with a==0 goes directly to DONE, giving res_valid after edge T with res_c=0.
  - n = bit length of a.
  - Latency is data-dependent.
- Undefined:
  - Always W iterations, so n=W and latency is constant at 2W edges.
  - Constant-time for side-channel resistance.
  - a==0 still runs all W iterations and yields 0.
- Results are identical in both builds.

Test Plan:
- req0 a=1, b=5, res_ready=1 → res_c=5, res_tag=0. res_valid after edge T+2 with MMUL_EARLY_TERM_EN, T+512 without.
- req1 a=32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7, b=BC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0 → res_c == (a·b) mod P from a 512-bit golden model; res_tag=1.
- a=P−1, b=P−1 → res_c=1. Also check no intermediate c or b_r ever reaches ≥P after RED.
- Both valid continuously, 4 ops → grant order 0,1,0,1. The non-granted ready stays 0 throughout.
- res_ready held 0 for 10 cycles in DONE → res_c/res_tag stable, busy=1, both req ready=0. Raise res_ready → IDLE next edge.
- rst pulsed for 1 cycle mid-ADD → next cycle state IDLE, res_valid=0, busy=0. A following request computes correctly.
